// File: rtl/decode_queue.sv
// Instruction queue between fetch and decode: prefix push of up to IN_W lanes,
// predecode on entry, in-order presentation of the OUT_W oldest entries.
module decode_queue #(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned IN_W    = 2,
  parameter int unsigned OUT_W   = 2,
  parameter int unsigned BPTAG_W = 16,
  localparam int unsigned CW     = $clog2(DEPTH + 1),
  localparam int unsigned TW     = $clog2(OUT_W + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [IN_W-1:0]          i_fetch_valid,
  input  logic [IN_W-1:0]          i_fetch_error,
  input  logic [31*IN_W-1:0]       i_fetch_addr,
  input  logic [32*IN_W-1:0]       i_fetch_insn,
  input  logic [BPTAG_W*IN_W-1:0]  i_fetch_bptag,
  input  logic [IN_W-1:0]          i_fetch_bptaken,
  output logic                     o_queue_stall,
  output logic [OUT_W-1:0]         o_out_valid,
  output logic [OUT_W-1:0]         o_out_error,
  output logic [OUT_W-1:0]         o_out_illegal,
  output logic [OUT_W-1:0]         o_out_branch,
  output logic [OUT_W-1:0]         o_out_mem,
  output logic [31*OUT_W-1:0]      o_out_addr,
  output logic [32*OUT_W-1:0]      o_out_insn,
  output logic [BPTAG_W*OUT_W-1:0] o_out_bptag,
  output logic [OUT_W-1:0]         o_out_bptaken,
  input  logic [TW-1:0]            i_out_take,
  input  logic                     i_rob_flush,
  output logic [CW-1:0]            o_queue_count
);

  localparam int unsigned PW = $clog2(DEPTH);

  localparam logic [6:0] OpLoad    = 7'b0000011;
  localparam logic [6:0] OpStore   = 7'b0100011;
  localparam logic [6:0] OpOpImm   = 7'b0010011;
  localparam logic [6:0] OpOp      = 7'b0110011;
  localparam logic [6:0] OpLui     = 7'b0110111;
  localparam logic [6:0] OpAuipc   = 7'b0010111;
  localparam logic [6:0] OpBranch  = 7'b1100011;
  localparam logic [6:0] OpJal     = 7'b1101111;
  localparam logic [6:0] OpJalr    = 7'b1100111;
  localparam logic [6:0] OpMiscMem = 7'b0001111;
  localparam logic [6:0] OpSystem  = 7'b1110011;

  // Storage is deliberately not reset; only pointers and count are.
  logic [30:0]        r_addr  [DEPTH];
  logic [31:0]        r_insn  [DEPTH];
  logic [BPTAG_W-1:0] r_bptag [DEPTH];
  logic [DEPTH-1:0]   r_error;
  logic [DEPTH-1:0]   r_illegal;
  logic [DEPTH-1:0]   r_branch;
  logic [DEPTH-1:0]   r_mem;
  logic [DEPTH-1:0]   r_bptaken;

  logic [PW-1:0]      r_head;
  logic [PW-1:0]      r_tail;
  logic [CW-1:0]      r_count;

  logic [CW-1:0]      w_free;
  logic               w_stall;
  logic [CW-1:0]      w_n_in;
  logic               w_gap;
  logic [CW-1:0]      w_avail;
  logic [CW-1:0]      w_take_req;
  logic [CW-1:0]      w_n_take;
  logic [6:0]         w_op;
  logic               w_legal;
  logic [IN_W-1:0]    w_pd_illegal;
  logic [IN_W-1:0]    w_pd_branch;
  logic [IN_W-1:0]    w_pd_mem;
  logic [PW-1:0]      w_widx [IN_W];
  logic [PW-1:0]      w_ridx [OUT_W];

  // Stall looks only at the registered count; a same-cycle pop gives no credit.
  always_comb begin
    w_free  = CW'(DEPTH) - r_count;
    w_stall = w_free < CW'(IN_W);
    w_n_in  = '0;
    w_gap   = 1'b0;
    for (int k = 0; k < IN_W; k++) begin
      if (!i_fetch_valid[k]) begin
        w_gap = 1'b1;
      end else if (!w_gap) begin
        w_n_in = w_n_in + CW'(1);
      end
    end
    if (w_stall) begin
      w_n_in = '0;
    end
    w_avail    = (r_count < CW'(OUT_W)) ? r_count : CW'(OUT_W);
    w_take_req = CW'(i_out_take);
    w_n_take   = (w_take_req > w_avail) ? w_avail : w_take_req;
  end

  always_comb begin
    w_op         = '0;
    w_legal      = 1'b0;
    w_pd_illegal = '0;
    w_pd_branch  = '0;
    w_pd_mem     = '0;
    for (int k = 0; k < IN_W; k++) begin
      w_op    = i_fetch_insn[k*32 +: 7];
      w_legal = (w_op[1:0] == 2'b11) &&
                (w_op inside {OpLoad, OpStore, OpOpImm, OpOp, OpLui, OpAuipc,
                              OpBranch, OpJal, OpJalr, OpMiscMem, OpSystem});
      w_pd_branch[k]  = w_op inside {OpBranch, OpJal, OpJalr};
      w_pd_mem[k]     = w_op inside {OpLoad, OpStore};
      // A fetch fault masks the illegal flag so decode reports the fault.
      w_pd_illegal[k] = ~i_fetch_error[k] & ~w_legal;
      w_widx[k]       = r_tail + PW'(k);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !i_rob_flush) begin
      for (int k = 0; k < IN_W; k++) begin
        if (CW'(k) < w_n_in) begin
          r_addr[w_widx[k]]    <= i_fetch_addr[k*31 +: 31];
          r_insn[w_widx[k]]    <= i_fetch_insn[k*32 +: 32];
          r_bptag[w_widx[k]]   <= i_fetch_bptag[k*BPTAG_W +: BPTAG_W];
          r_error[w_widx[k]]   <= i_fetch_error[k];
          r_illegal[w_widx[k]] <= w_pd_illegal[k];
          r_branch[w_widx[k]]  <= w_pd_branch[k];
          r_mem[w_widx[k]]     <= w_pd_mem[k];
          r_bptaken[w_widx[k]] <= i_fetch_bptaken[k];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || i_rob_flush) begin
      r_count <= '0;
      r_head  <= '0;
      r_tail  <= '0;
    end else begin
      r_count <= r_count + w_n_in - w_n_take;
      r_head  <= r_head + w_n_take[PW-1:0];
      r_tail  <= r_tail + w_n_in[PW-1:0];
    end
  end

  always_comb begin
    o_out_valid   = '0;
    o_out_error   = '0;
    o_out_illegal = '0;
    o_out_branch  = '0;
    o_out_mem     = '0;
    o_out_addr    = '0;
    o_out_insn    = '0;
    o_out_bptag   = '0;
    o_out_bptaken = '0;
    for (int j = 0; j < OUT_W; j++) begin
      w_ridx[j]                          = r_head + PW'(j);
      o_out_valid[j]                     = CW'(j) < r_count;
      o_out_error[j]                     = r_error[w_ridx[j]];
      o_out_illegal[j]                   = r_illegal[w_ridx[j]];
      o_out_branch[j]                    = r_branch[w_ridx[j]];
      o_out_mem[j]                       = r_mem[w_ridx[j]];
      o_out_addr[j*31 +: 31]             = r_addr[w_ridx[j]];
      o_out_insn[j*32 +: 32]             = r_insn[w_ridx[j]];
      o_out_bptag[j*BPTAG_W +: BPTAG_W]  = r_bptag[w_ridx[j]];
      o_out_bptaken[j]                   = r_bptaken[w_ridx[j]];
    end
  end

  assign o_queue_stall = w_stall;
  assign o_queue_count = r_count;

endmodule

// File: tb/tb_decode_queue.sv
// Bench for decode_queue: directed scenarios plus randomized traffic checked
// against a queue-based reference model.
module tb_decode_queue;

  localparam int DEPTH   = 8;
  localparam int IN_W    = 2;
  localparam int OUT_W   = 2;
  localparam int BPTAG_W = 16;
  localparam int CW      = $clog2(DEPTH + 1);
  localparam int TW      = $clog2(OUT_W + 1);

  logic                     clk = 1'b0;
  logic                     rst;
  logic [IN_W-1:0]          fetch_valid;
  logic [IN_W-1:0]          fetch_error;
  logic [31*IN_W-1:0]       fetch_addr;
  logic [32*IN_W-1:0]       fetch_insn;
  logic [BPTAG_W*IN_W-1:0]  fetch_bptag;
  logic [IN_W-1:0]          fetch_bptaken;
  logic                     queue_stall;
  logic [OUT_W-1:0]         out_valid, out_error, out_illegal, out_branch, out_mem;
  logic [31*OUT_W-1:0]      out_addr;
  logic [32*OUT_W-1:0]      out_insn;
  logic [BPTAG_W*OUT_W-1:0] out_bptag;
  logic [OUT_W-1:0]         out_bptaken;
  logic [TW-1:0]            out_take;
  logic                     rob_flush;
  logic [CW-1:0]            queue_count;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic         err;
    logic         ill;
    logic         br;
    logic         mem;
    logic         tk;
    logic [30:0]  addr;
    logic [31:0]  insn;
    logic [15:0]  tag;
  } ent_t;

  ent_t mq[$];

  logic [6:0] legal_ops [11] = '{7'h03, 7'h23, 7'h13, 7'h33, 7'h37, 7'h17,
                                 7'h63, 7'h6F, 7'h67, 7'h0F, 7'h73};

  decode_queue #(.DEPTH(DEPTH), .IN_W(IN_W), .OUT_W(OUT_W), .BPTAG_W(BPTAG_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .i_fetch_valid   (fetch_valid),
    .i_fetch_error   (fetch_error),
    .i_fetch_addr    (fetch_addr),
    .i_fetch_insn    (fetch_insn),
    .i_fetch_bptag   (fetch_bptag),
    .i_fetch_bptaken (fetch_bptaken),
    .o_queue_stall   (queue_stall),
    .o_out_valid     (out_valid),
    .o_out_error     (out_error),
    .o_out_illegal   (out_illegal),
    .o_out_branch    (out_branch),
    .o_out_mem       (out_mem),
    .o_out_addr      (out_addr),
    .o_out_insn      (out_insn),
    .o_out_bptag     (out_bptag),
    .o_out_bptaken   (out_bptaken),
    .i_out_take      (out_take),
    .i_rob_flush     (rob_flush),
    .o_queue_count   (queue_count)
  );

  always #5 clk = ~clk;

  // Taking more than is presented is a bench bug, not a DUT one.
  always @(posedge clk) begin
    if (!rst) assert (int'(out_take) <= $countones(out_valid));
  end

  function automatic ent_t mk_entry(input int k);
    ent_t e;
    logic legal;
    e.err  = fetch_error[k];
    e.insn = fetch_insn[k*32 +: 32];
    e.addr = fetch_addr[k*31 +: 31];
    e.tag  = fetch_bptag[k*BPTAG_W +: BPTAG_W];
    e.tk   = fetch_bptaken[k];
    legal  = 1'b0;
    for (int i = 0; i < 11; i++) if (e.insn[6:0] == legal_ops[i]) legal = 1'b1;
    if (e.insn[1:0] != 2'b11) legal = 1'b0;
    e.ill  = !e.err && !legal;
    e.br   = e.insn[6:0] == 7'h63 || e.insn[6:0] == 7'h6F || e.insn[6:0] == 7'h67;
    e.mem  = e.insn[6:0] == 7'h03 || e.insn[6:0] == 7'h23;
    return e;
  endfunction

  // Advance the model with the current inputs, then let the DUT take the edge.
  task automatic tick();
    int n_in, n_take, avail;
    bit gap, stall_m;
    stall_m = (DEPTH - mq.size()) < IN_W;
    n_in = 0;
    gap  = 1'b0;
    for (int k = 0; k < IN_W; k++) begin
      if (!fetch_valid[k]) gap = 1'b1;
      else if (!gap) n_in++;
    end
    if (stall_m) n_in = 0;
    avail  = (mq.size() < OUT_W) ? mq.size() : OUT_W;
    n_take = (int'(out_take) > avail) ? avail : int'(out_take);
    if (rst || rob_flush) begin
      mq.delete();
    end else begin
      repeat (n_take) void'(mq.pop_front());
      for (int k = 0; k < n_in; k++) mq.push_back(mk_entry(k));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    fetch_valid = '0; fetch_error = '0; fetch_addr = '0; fetch_insn = '0;
    fetch_bptag = '0; fetch_bptaken = '0; out_take = '0; rob_flush = 1'b0;
  endtask

  task automatic set_push(input logic [1:0] vld, input logic [1:0] err,
                          input logic [31:0] i0, input logic [31:0] i1,
                          input logic [31:0] pc0, input logic [31:0] pc1);
    fetch_valid   = vld;
    fetch_error   = err;
    fetch_insn    = {i1, i0};
    fetch_addr    = {pc1[31:1], pc0[31:1]};
    fetch_bptag   = {16'($urandom), 16'($urandom)};
    fetch_bptaken = 2'($urandom);
  endtask

  task automatic drain();
    idle();
    for (int i = 0; i < DEPTH; i++) begin
      out_take = (mq.size() >= OUT_W) ? TW'(OUT_W) : TW'(mq.size());
      tick();
    end
    idle();
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (out_valid !== '0) begin errors++; $display("FAIL reset_valid got %b want 00", out_valid); end
    checks++;
    if (queue_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", queue_stall); end
    checks++;
    if (queue_count !== '0) begin errors++; $display("FAIL reset_count got %0d want 0", queue_count); end
  endtask

  task automatic test_basic();
    set_push(2'b11, 2'b00, 32'h0000_0013, 32'h0000_006F, 32'h100, 32'h104);
    tick();
    idle();
    checks++;
    if (out_valid !== 2'b11) begin errors++; $display("FAIL basic_valid got %b want 11", out_valid); end
    checks++;
    if (out_branch !== 2'b10) begin errors++; $display("FAIL basic_branch got %b want 10", out_branch); end
    checks++;
    if (out_illegal !== 2'b00) begin errors++; $display("FAIL basic_illegal got %b want 00", out_illegal); end
    checks++;
    if (queue_count !== CW'(2)) begin errors++; $display("FAIL basic_count got %0d want 2", queue_count); end
    checks++;
    if (out_addr !== {31'h82, 31'h80}) begin
      errors++; $display("FAIL basic_addr got %h want %h", out_addr, {31'h82, 31'h80});
    end
    drain();
  endtask

  task automatic test_stall();
    for (int i = 0; i < 3; i++) begin
      set_push(2'b11, 2'b00, 32'h13, 32'h13, 32'h300 + 8 * i, 32'h304 + 8 * i);
      tick();
    end
    checks++;
    if (queue_count !== CW'(6)) begin errors++; $display("FAIL stall_count6 got %0d want 6", queue_count); end
    checks++;
    if (queue_stall !== 1'b0) begin errors++; $display("FAIL stall_at6 got %b want 0", queue_stall); end
    tick();
    checks++;
    if (queue_stall !== 1'b1) begin errors++; $display("FAIL stall_full got %b want 1", queue_stall); end
    tick();
    checks++;
    if (queue_count !== CW'(8)) begin errors++; $display("FAIL stall_ignored got %0d want 8", queue_count); end
    out_take = TW'(1);
    tick();
    checks++;
    if (queue_stall !== 1'b1 || queue_count !== CW'(7)) begin
      errors++; $display("FAIL stall_at7 got %b/%0d want 1/7", queue_stall, queue_count);
    end
    fetch_valid = '0;
    tick();
    checks++;
    if (queue_stall !== 1'b0 || queue_count !== CW'(6)) begin
      errors++; $display("FAIL stall_release got %b/%0d want 0/6", queue_stall, queue_count);
    end
    drain();
  endtask

  task automatic test_wrap();
    set_push(2'b11, 2'b00, 32'h13, 32'h13, 32'h200, 32'h204);
    tick();
    for (int i = 0; i < 10; i++) begin
      set_push(2'b11, 2'b00, 32'h13, 32'h13, 32'h200 + 8 * (i + 1), 32'h204 + 8 * (i + 1));
      out_take = TW'(2);
      tick();
      checks++;
      if (out_addr[30:0] !== 31'((32'h200 + 8 * (i + 1)) >> 1) ||
          out_addr[61:31] !== 31'((32'h204 + 8 * (i + 1)) >> 1) || queue_count !== CW'(2)) begin
        errors++;
        $display("FAIL wrap_%0d got %h/%h cnt %0d want %h/%h cnt 2", i, out_addr[30:0],
                 out_addr[61:31], queue_count, 31'((32'h200 + 8 * (i + 1)) >> 1),
                 31'((32'h204 + 8 * (i + 1)) >> 1));
      end
    end
    drain();
  endtask

  task automatic test_gap_and_illegal();
    set_push(2'b10, 2'b00, 32'h13, 32'h13, 32'h400, 32'h404);
    tick();
    checks++;
    if (queue_count !== '0 || out_valid !== '0) begin
      errors++; $display("FAIL gap_push got %0d/%b want 0/00", queue_count, out_valid);
    end
    set_push(2'b01, 2'b00, 32'h0000_000B, 32'h13, 32'h408, 32'h40C);
    tick();
    checks++;
    if (out_illegal[0] !== 1'b1 || out_error[0] !== 1'b0) begin
      errors++; $display("FAIL illegal_custom got %b/%b want 1/0", out_illegal[0], out_error[0]);
    end
    set_push(2'b01, 2'b01, 32'h0000_000B, 32'h13, 32'h410, 32'h414);
    out_take = TW'(1);
    tick();
    checks++;
    if (out_illegal[0] !== 1'b0 || out_error[0] !== 1'b1 || queue_count !== CW'(1)) begin
      errors++;
      $display("FAIL error_masks_illegal got %b/%b/%0d want 0/1/1", out_illegal[0], out_error[0],
               queue_count);
    end
    drain();
  endtask

  task automatic test_flush();
    for (int i = 0; i < 4; i++) begin
      set_push(2'b11, 2'b00, 32'h23, 32'h03, 32'h500 + 8 * i, 32'h504 + 8 * i);
      tick();
    end
    checks++;
    if (queue_count !== CW'(8)) begin errors++; $display("FAIL flush_fill got %0d want 8", queue_count); end
    set_push(2'b11, 2'b00, 32'h13, 32'h13, 32'h600, 32'h604);
    out_take  = TW'(2);
    rob_flush = 1'b1;
    tick();
    checks++;
    if (queue_count !== '0 || out_valid !== '0) begin
      errors++; $display("FAIL flush_clear got %0d/%b want 0/00", queue_count, out_valid);
    end
    idle();
    set_push(2'b11, 2'b00, 32'h13, 32'h13, 32'h700, 32'h704);
    tick();
    checks++;
    if (queue_count !== CW'(2) || out_addr[30:0] !== 31'h380) begin
      errors++; $display("FAIL flush_refill got %0d/%h want 2/380", queue_count, out_addr[30:0]);
    end
    idle();
    rob_flush = 1'b1;
    tick();
    idle();
  endtask

  task automatic test_random();
    int avail;
    ent_t got;
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < IN_W; k++) begin
        case ($urandom_range(0, 3))
          0:       fetch_insn[k*32 +: 32] = $urandom;
          default: fetch_insn[k*32 +: 32] = {25'($urandom), legal_ops[$urandom_range(0, 10)]};
        endcase
        fetch_addr[k*31 +: 31]            = 31'($urandom);
        fetch_bptag[k*BPTAG_W +: BPTAG_W] = 16'($urandom);
      end
      fetch_valid   = 2'($urandom);
      fetch_error   = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00;
      fetch_bptaken = 2'($urandom);
      avail         = (mq.size() < OUT_W) ? mq.size() : OUT_W;
      out_take      = TW'($urandom_range(0, avail));
      rob_flush     = ($urandom_range(0, 39) == 0);
      tick();
      checks++;
      if (queue_count !== CW'(mq.size())) begin
        errors++; $display("FAIL rnd_count c%0d got %0d want %0d", c, queue_count, mq.size());
      end
      checks++;
      if (queue_stall !== ((DEPTH - mq.size()) < IN_W)) begin
        errors++; $display("FAIL rnd_stall c%0d got %b cnt %0d", c, queue_stall, mq.size());
      end
      for (int j = 0; j < OUT_W; j++) begin
        checks++;
        if (out_valid[j] !== (j < mq.size())) begin
          errors++; $display("FAIL rnd_valid c%0d lane %0d got %b", c, j, out_valid[j]);
        end
        if (j < mq.size()) begin
          got = {out_error[j], out_illegal[j], out_branch[j], out_mem[j], out_bptaken[j],
                 out_addr[j*31 +: 31], out_insn[j*32 +: 32], out_bptag[j*BPTAG_W +: BPTAG_W]};
          checks++;
          if (got !== mq[j]) begin
            errors++; $display("FAIL rnd_entry c%0d lane %0d got %h want %h", c, j, got, mq[j]);
          end
        end
      end
    end
    idle();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_basic();
    test_stall();
    test_wrap();
    test_gap_and_illegal();
    test_flush();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
